trap_controller: RTL and testbench



---
 rtl/trap_controller_if.sv | 20 ++
 rtl/trap_controller.sv | 165 ++++++++++++++++
 tb/tb_trap_controller.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/trap_controller_if.sv
// CSR file port bundle between the trap sequencer (master) and the CSR file (slave).
interface trap_controller_if #(
  parameter int XLEN = 32
);
  logic            csr_write_enable;
  logic [11:0]     csr_trap_address;
  logic [XLEN-1:0] csr_trap_write_data;
  logic [XLEN-1:0] csr_read_data;
  logic            csr_ready;

  modport master (
    output csr_write_enable, csr_trap_address, csr_trap_write_data,
    input  csr_read_data, csr_ready
  );

  modport slave (
    input  csr_write_enable, csr_trap_address, csr_trap_write_data,
    output csr_read_data, csr_ready
  );
endinterface

// File: rtl/trap_controller.sv
// Trap/return sequencer: writes mepc/mcause, reads mtvec/mepc, redirects the PC.
// Optional feature macro: DEBUG_EBREAK_EN (EBREAK halts into debug mode instead of trapping).
module trap_controller #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      trap_status,
  input  logic [XLEN-1:0] pc,
  input  logic            debug_resume,
  trap_controller_if.master csr,
  output logic [XLEN-1:0] trap_target,
  output logic            trap_done,
  output logic            pc_stall,
  output logic            debug_mode
);

  localparam logic [2:0]  TS_NONE    = 3'b000;
  localparam logic [2:0]  TS_EBREAK  = 3'b010;
  localparam logic [2:0]  TS_MRET    = 3'b011;
  localparam logic [11:0] ADDR_MTVEC = 12'h305;
  localparam logic [11:0] ADDR_MEPC  = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE = 12'h342;

  typedef enum logic [3:0] {
    IDLE, WR_MEPC, GAP0, WR_MCAUSE, GAP1, RD_MTVEC, RD_MEPC, HALT, DONE
  } state_t;

  function automatic logic [3:0] cause_code(input logic [2:0] status);
    case (status)
      3'b001:  cause_code = 4'd11;
      3'b010:  cause_code = 4'd3;
      3'b100:  cause_code = 4'd0;
      3'b101:  cause_code = 4'd6;
      3'b110:  cause_code = 4'd4;
      3'b111:  cause_code = 4'd2;
      default: cause_code = 4'd0;
    endcase
  endfunction

  state_t          state_r, state_nxt;
  logic [XLEN-1:0] pc_r;
  logic [3:0]      cause_r;
  logic            read_wait_r;
  logic            capture_s;
  logic            we_nxt, done_nxt, debug_nxt;
  logic [11:0]     addr_nxt;
  logic [XLEN-1:0] wdata_nxt, target_nxt;

  // read_wait keeps the first cycle of a read state from capturing stale data
  assign capture_s = (state_r == RD_MTVEC || state_r == RD_MEPC) && read_wait_r && csr.csr_ready;
  assign pc_stall  = (state_r == IDLE) ? (trap_status != TS_NONE) : (state_r != DONE);

`ifdef DEBUG_EBREAK_EN
  logic [1:0] unused_bits;
  assign unused_bits = csr.csr_read_data[1:0];
`else
  logic [XLEN+2:0] unused_bits;
  assign unused_bits = {debug_resume, pc_r, csr.csr_read_data[1:0]};
`endif

  // state register plus latched pc/cause and the read handshake flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      pc_r        <= {XLEN{1'b0}};
      cause_r     <= 4'd0;
      read_wait_r <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      read_wait_r <= (state_r == RD_MTVEC || state_r == RD_MEPC) && !capture_s;
      if (state_r == IDLE && (state_nxt == WR_MEPC || state_nxt == HALT)) begin
        pc_r    <= pc;
        cause_r <= cause_code(trap_status);
      end else begin
        pc_r    <= pc_r;
        cause_r <= cause_r;
      end
    end
  end

  // next-state decode
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (trap_status == TS_NONE) state_nxt = IDLE;
        else if (trap_status == TS_MRET) state_nxt = RD_MEPC;
`ifdef DEBUG_EBREAK_EN
        else if (trap_status == TS_EBREAK) state_nxt = HALT;
`endif
        else state_nxt = WR_MEPC;
      end
      WR_MEPC:   state_nxt = GAP0;
      GAP0:      state_nxt = WR_MCAUSE;
      WR_MCAUSE: state_nxt = GAP1;
      GAP1:      state_nxt = RD_MTVEC;
      RD_MTVEC, RD_MEPC: begin
        if (capture_s) state_nxt = DONE;
        else state_nxt = state_r;
      end
`ifdef DEBUG_EBREAK_EN
      HALT: begin
        if (debug_resume) state_nxt = DONE;
        else state_nxt = HALT;
      end
`else
      HALT:      state_nxt = IDLE;
`endif
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // output values for the coming state; gaps drop the enable so each write sees a rising edge
  always_comb begin
    we_nxt = (state_nxt == WR_MEPC) || (state_nxt == WR_MCAUSE);
    case (state_nxt)
      WR_MEPC, RD_MEPC: addr_nxt = ADDR_MEPC;
      WR_MCAUSE:        addr_nxt = ADDR_MCAUSE;
      RD_MTVEC:         addr_nxt = ADDR_MTVEC;
      default:          addr_nxt = 12'h000;
    endcase
    case (state_nxt)
      WR_MEPC:   wdata_nxt = pc;
      WR_MCAUSE: wdata_nxt = {{(XLEN-4){1'b0}}, cause_r};
      default:   wdata_nxt = {XLEN{1'b0}};
    endcase
    if (capture_s) begin
      target_nxt = {csr.csr_read_data[XLEN-1:2], 2'b00};
`ifdef DEBUG_EBREAK_EN
    end else if (state_r == HALT && debug_resume) begin
      target_nxt = pc_r + XLEN'(4);
`endif
    end else begin
      target_nxt = trap_target;
    end
    done_nxt = (state_nxt == DONE);
`ifdef DEBUG_EBREAK_EN
    debug_nxt = (state_nxt == HALT);
`else
    debug_nxt = 1'b0;
`endif
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      csr.csr_write_enable    <= 1'b0;
      csr.csr_trap_address    <= 12'h000;
      csr.csr_trap_write_data <= {XLEN{1'b0}};
      trap_target             <= {XLEN{1'b0}};
      trap_done               <= 1'b0;
      debug_mode              <= 1'b0;
    end else begin
      csr.csr_write_enable    <= we_nxt;
      csr.csr_trap_address    <= addr_nxt;
      csr.csr_trap_write_data <= wdata_nxt;
      trap_target             <= target_nxt;
      trap_done               <= done_nxt;
      debug_mode              <= debug_nxt;
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller with a small CSR-file model (1-cycle read stall).
module tb_trap_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  trap_status;
  logic [31:0] pc;
  logic        debug_resume;
  logic [31:0] trap_target;
  logic        trap_done, pc_stall, debug_mode;

  trap_controller_if #(.XLEN(32)) bus ();

  trap_controller #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .trap_status(trap_status), .pc(pc),
    .debug_resume(debug_resume), .csr(bus), .trap_target(trap_target),
    .trap_done(trap_done), .pc_stall(pc_stall), .debug_mode(debug_mode)
  );

  always #5 clk = ~clk;

  // CSR file model: writes on the enable's rising edge, ready one cycle after the address settles
  logic [31:0] mtvec = 32'h0;
  logic [31:0] mepc_q = 32'h0;
  logic [31:0] mcause_q = 32'h0;
  logic        we_prev = 1'b0;
  logic [11:0] addr_prev = 12'h0;
  logic        ready_en;
  int          wr_count = 0;

  always @(posedge clk) begin
    we_prev   <= bus.csr_write_enable;
    addr_prev <= bus.csr_trap_address;
    if (bus.csr_write_enable && !we_prev) begin
      wr_count <= wr_count + 1;
      if (bus.csr_trap_address == 12'h341) mepc_q <= bus.csr_trap_write_data;
      else if (bus.csr_trap_address == 12'h342) mcause_q <= bus.csr_trap_write_data;
    end
  end

  assign bus.csr_read_data = (bus.csr_trap_address == 12'h305) ? mtvec :
                             (bus.csr_trap_address == 12'h341) ? mepc_q :
                             (bus.csr_trap_address == 12'h342) ? mcause_q : 32'h0;
  assign bus.csr_ready = ready_en && (bus.csr_trap_address != 12'h0) &&
                         (bus.csr_trap_address == addr_prev);

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // reference state: architectural mepc/mcause as the trap rules say they should be
  logic [31:0] m_mepc = 32'h0;
  logic [31:0] m_mcause = 32'h0;
  logic [31:0] cause_tab [8] = '{32'd0, 32'd11, 32'd3, 32'd0, 32'd0, 32'd6, 32'd4, 32'd2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one trap or return from detection cycle T (c=0) until two cycles after trap_done
  task automatic do_event(input logic [2:0] code, input logic [31:0] pcv, input int extra,
                          input string tag);
    bit          is_mret = (code == 3'b011);
    int          lat = (is_mret ? 3 : 7) + extra;
    int          rd_first = is_mret ? 1 : 5;
    int          nwe = 0, ndone = 0, done_cyc = -1, stall_bad = 0;
    int          we_cyc [2];
    logic [11:0] we_addr [2];
    logic [31:0] we_data [2];
    logic [11:0] rd_addr = 12'h0;
    logic [31:0] got_target = 32'h0;
    logic [31:0] exp_target;
    for (int i = 0; i < 2; i++) begin
      we_cyc[i] = -1; we_addr[i] = 12'h0; we_data[i] = 32'h0;
    end
    if (is_mret) begin
      exp_target = {m_mepc[31:2], 2'b00};
    end else begin
      m_mepc     = pcv;
      m_mcause   = cause_tab[code];
      exp_target = {mtvec[31:2], 2'b00};
    end
    trap_status = code;
    pc = pcv;
    for (int c = 0; c <= lat + 2; c++) begin
      @(negedge clk);
      if (bus.csr_write_enable) begin
        if (nwe < 2) begin
          we_cyc[nwe] = c; we_addr[nwe] = bus.csr_trap_address; we_data[nwe] = bus.csr_trap_write_data;
        end
        nwe++;
      end
      if (trap_done) begin
        ndone++; done_cyc = c; got_target = trap_target;
      end
      if (pc_stall !== ((c < lat) ? 1'b1 : 1'b0)) stall_bad++;
      if (c == lat - 1) rd_addr = bus.csr_trap_address;
      if (c == 1) trap_status = 3'b000;
      if (extra > 0 && c == rd_first) ready_en = 1'b0;
      if (c == rd_first + extra + 1) ready_en = 1'b1;
    end
    check({tag, " done_cycle"}, done_cyc, lat);
    check({tag, " done_pulses"}, ndone, 1);
    check({tag, " trap_target"}, got_target, exp_target);
    check({tag, " stall_profile_errors"}, stall_bad, 0);
    check({tag, " read_addr"}, 32'(rd_addr), is_mret ? 32'h341 : 32'h305);
    check({tag, " write_pulses"}, nwe, is_mret ? 0 : 2);
    if (!is_mret) begin
      check({tag, " mepc_wr_cycle"}, we_cyc[0], 1);
      check({tag, " mepc_wr_addr"}, 32'(we_addr[0]), 32'h341);
      check({tag, " mepc_wr_data"}, we_data[0], pcv);
      check({tag, " mcause_wr_cycle"}, we_cyc[1], 3);
      check({tag, " mcause_wr_addr"}, 32'(we_addr[1]), 32'h342);
    end
    check({tag, " mepc"}, mepc_q, m_mepc);
    check({tag, " mcause"}, mcause_q, m_mcause);
    @(posedge clk); #1;
  endtask

  initial begin
    int wr0;
    int dn;
    logic [2:0] code;
    reset = 1'b1; trap_status = 3'b000; pc = 32'h0; debug_resume = 1'b0; ready_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset we", 32'(bus.csr_write_enable), 32'h0);
    check("reset addr", 32'(bus.csr_trap_address), 32'h0);
    check("reset wdata", bus.csr_trap_write_data, 32'h0);
    check("reset target", trap_target, 32'h0);
    check("reset done", 32'(trap_done), 32'h0);
    check("reset stall", 32'(pc_stall), 32'h0);
    check("reset debug", 32'(debug_mode), 32'h0);
    @(posedge clk); #1;

    mtvec = 32'h0000_1000;
    do_event(3'b001, 32'h0000_0100, 0, "ecall");
    do_event(3'b011, 32'h0000_0abc, 0, "mret");
    mtvec = 32'h0000_2003;
    do_event(3'b110, 32'h0000_0204, 0, "misaligned_load");
    do_event(3'b001, 32'h0000_0500, 5, "ready_stall5");

    // reset lands while the sequencer sits in GAP0
    wr0 = wr_count;
    m_mepc = 32'h0000_0400;
    trap_status = 3'b111; pc = 32'h0000_0400;
    @(posedge clk); #1 trap_status = 3'b000;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("gap0_reset we", 32'(bus.csr_write_enable), 32'h0);
    check("gap0_reset addr", 32'(bus.csr_trap_address), 32'h0);
    check("gap0_reset wdata", bus.csr_trap_write_data, 32'h0);
    check("gap0_reset target", trap_target, 32'h0);
    check("gap0_reset stall", 32'(pc_stall), 32'h0);
    check("gap0_reset debug", 32'(debug_mode), 32'h0);
    dn = 32'(trap_done);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dn += 32'(trap_done) + 32'(bus.csr_write_enable);
    end
    check("gap0_reset no_done_no_write", dn, 0);
    check("gap0_reset writes", wr_count - wr0, 1);
    check("gap0_reset mepc", mepc_q, m_mepc);
    check("gap0_reset mcause", mcause_q, m_mcause);
    @(posedge clk); #1;

`ifdef DEBUG_EBREAK_EN
    wr0 = wr_count;
    trap_status = 3'b010; pc = 32'h0000_0300;
    @(negedge clk);
    check("debug stall_T", 32'(pc_stall), 32'h1);
    @(posedge clk); #1 trap_status = 3'b000;
    @(negedge clk);
    check("debug mode_on", 32'(debug_mode), 32'h1);
    repeat (3) @(negedge clk);
    check("debug stall_halt", 32'(pc_stall), 32'h1);
    check("debug still_on", 32'(debug_mode), 32'h1);
    check("debug no_done", 32'(trap_done), 32'h0);
    check("debug no_writes", wr_count - wr0, 0);
    @(posedge clk); #1 debug_resume = 1'b1;
    @(posedge clk); #1 debug_resume = 1'b0;
    @(negedge clk);
    check("debug done", 32'(trap_done), 32'h1);
    check("debug target", trap_target, 32'h0000_0304);
    check("debug mode_off", 32'(debug_mode), 32'h0);
    check("debug stall_done", 32'(pc_stall), 32'h0);
    @(negedge clk);
    check("debug done_one_cycle", 32'(trap_done), 32'h0);
    @(posedge clk); #1;
`else
    mtvec = 32'h0000_3000;
    do_event(3'b010, 32'h0000_0300, 0, "ebreak");
`endif

    for (int k = 0; k < 24; k++) begin
      code = 3'($urandom_range(1, 7));
`ifdef DEBUG_EBREAK_EN
      if (code == 3'b010) code = 3'b001;
`endif
      mtvec = $urandom;
      do_event(code, $urandom, int'($urandom_range(0, 3)), $sformatf("rand%0d", k));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
